// File: rtl/btb_assoc_if.sv
// btb_assoc_if: lookup, resolution-update, flush and statistics signals of the branch target buffer
interface btb_assoc_if #(
  parameter int WIDTH = 31,
  parameter int B_WIDTH = 7
);
  logic [B_WIDTH:0] PC;
  logic [B_WIDTH:0] oldPC;
  logic [WIDTH:0] resolvedTarget;
  logic writeBTB;
  logic takenBranch;
  logic flush;
  logic validRead;
  logic [WIDTH:0] targetAddress;
  logic flushBusy;
  logic [31:0] lookupCount;
  logic [31:0] hitCount;
  modport master (
    output PC, oldPC, resolvedTarget, writeBTB, takenBranch, flush,
    input validRead, targetAddress, flushBusy, lookupCount, hitCount
  );
  modport slave (
    input PC, oldPC, resolvedTarget, writeBTB, takenBranch, flush,
    output validRead, targetAddress, flushBusy, lookupCount, hitCount
  );
endinterface

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative BTB with 2-bit confidence, round-robin replacement and a flush sweep
// Defining BTB_STATS_EN adds lookup/hit counters; otherwise both statistics outputs read 0.
module btb_assoc #(
  parameter int WIDTH = 31,
  parameter int B_WIDTH = 7,
  parameter int SETS = 16,
  parameter int WAYS = 2,
  parameter int TAG_BITS = 4
) (
  input logic clk,
  input logic reset,
  btb_assoc_if.slave bus
);
  localparam int IDX = $clog2(SETS);
  localparam int VW = WAYS > 1 ? $clog2(WAYS) : 1;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_n;
  logic [IDX-1:0] ptr, ptr_n;
  logic busy;
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0][TAG_BITS-1:0] tag_q [SETS];
  logic [WAYS-1:0][WIDTH:0] tgt_q [SETS];
  logic [WAYS-1:0][1:0] conf_q [SETS];
  logic [VW-1:0] vic_q [SETS];
  logic [IDX-1:0] wi, ri;
  logic [TAG_BITS-1:0] wt, rt, rd_tag;
  logic whit, winv;
  logic [VW-1:0] hw, iw, aw;
  logic [WAYS-1:0] rd_valid;
  logic [WAYS-1:0][TAG_BITS-1:0] rd_tags;
  logic [WAYS-1:0][WIDTH:0] rd_tgt;
  logic [WAYS-1:0][1:0] rd_conf;
  logic hit_r;
  logic [WIDTH:0] tgt_r;
  assign wi = bus.oldPC[IDX-1:0];
  assign wt = bus.oldPC[IDX+TAG_BITS-1:IDX];
  assign ri = bus.PC[IDX-1:0];
  assign rt = bus.PC[IDX+TAG_BITS-1:IDX];
  assign busy = state == SWEEP;
  assign bus.flushBusy = busy;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= SWEEP;
      ptr <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
    end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    if (bus.flush) begin
      state_n = SWEEP;
      ptr_n = '0;
    end else if (busy) begin
      ptr_n = ptr + 1'b1;
      state_n = ptr == IDX'(SETS - 1) ? IDLE : SWEEP;
    end
  end
  // Descending scan so the lowest-numbered matching / free way wins.
  always_comb begin
    whit = 1'b0;
    winv = 1'b0;
    hw = '0;
    iw = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[wi][w] && tag_q[wi][w] == wt) begin
        whit = 1'b1;
        hw = VW'(w);
      end
      if (!valid_q[wi][w]) begin
        winv = 1'b1;
        iw = VW'(w);
      end
    end
    aw = winv ? iw : vic_q[wi];
  end
  // Storage has no reset so it can map to RAM; the sweep invalidates it instead.
  always_ff @(posedge clk)
    if (busy) begin
      valid_q[ptr] <= '0;
      vic_q[ptr] <= '0;
    end else if (bus.writeBTB) begin
      if (whit && bus.takenBranch) begin
        tgt_q[wi][hw] <= bus.resolvedTarget;
        conf_q[wi][hw] <= conf_q[wi][hw] == 2'd3 ? 2'd3 : conf_q[wi][hw] + 2'd1;
      end else if (whit) begin
        if (conf_q[wi][hw] == 2'd0) valid_q[wi][hw] <= 1'b0;
        else conf_q[wi][hw] <= conf_q[wi][hw] - 2'd1;
      end else if (bus.takenBranch) begin
        valid_q[wi][aw] <= 1'b1;
        tag_q[wi][aw] <= wt;
        tgt_q[wi][aw] <= bus.resolvedTarget;
        conf_q[wi][aw] <= 2'd2;
        if (!winv) vic_q[wi] <= vic_q[wi] == VW'(WAYS - 1) ? '0 : vic_q[wi] + 1'b1;
      end
    end
  // Reads taken during the sweep may see not-yet-cleared sets, so they are masked.
  always_ff @(posedge clk) begin
    rd_valid <= busy ? '0 : valid_q[ri];
    rd_tags <= tag_q[ri];
    rd_tgt <= tgt_q[ri];
    rd_conf <= conf_q[ri];
    rd_tag <= rt;
  end
  always_comb begin
    hit_r = 1'b0;
    tgt_r = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (rd_valid[w] && rd_tags[w] == rd_tag && rd_conf[w][1]) begin
        hit_r = 1'b1;
        tgt_r = rd_tgt[w];
      end
  end
  assign bus.validRead = hit_r && !busy;
  assign bus.targetAddress = bus.validRead ? tgt_r : '0;
`ifdef BTB_STATS_EN
  logic [31:0] lc, hc;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      lc <= '0;
      hc <= '0;
    end else if (bus.flush) begin
      lc <= '0;
      hc <= '0;
    end else begin
      lc <= busy ? lc : lc + 32'd1;
      hc <= bus.validRead ? hc + 32'd1 : hc;
    end
  assign bus.lookupCount = lc;
  assign bus.hitCount = hc;
`else
  assign bus.lookupCount = '0;
  assign bus.hitCount = '0;
`endif
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed test-plan scenarios plus randomized traffic against a behavioural BTB model
module tb_btb_assoc;
  localparam int WIDTH = 31, B_WIDTH = 7, SETS = 16, WAYS = 2, TAG_BITS = 4;
`ifdef BTB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  btb_assoc_if #(.WIDTH(WIDTH), .B_WIDTH(B_WIDTH)) bus ();
  btb_assoc #(.WIDTH(WIDTH), .B_WIDTH(B_WIDTH), .SETS(SETS), .WAYS(WAYS), .TAG_BITS(TAG_BITS))
    dut (.clk(clk), .reset(reset), .bus(bus));
  bit m_v [SETS][WAYS];
  int m_tag [SETS][WAYS];
  logic [31:0] m_t [SETS][WAYS];
  int m_c [SETS][WAYS];
  int m_vic [SETS];
  int left = SETS;
  bit exp_busy = 1'b1, exp_vr = 1'b0;
  logic [31:0] exp_ta = '0, exp_lc = '0, exp_hc = '0;
  int n_chk = 0, n_fail = 0;
  bit chk_on = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (chk_on) begin
      chk("flushBusy", 64'(bus.flushBusy), 64'(exp_busy));
      chk("validRead", 64'(bus.validRead), 64'(exp_vr));
      chk("targetAddress", 64'(bus.targetAddress), 64'(exp_ta));
      chk("lookupCount", 64'(bus.lookupCount), 64'(STATS ? exp_lc : 32'd0));
      chk("hitCount", 64'(bus.hitCount), 64'(STATS ? exp_hc : 32'd0));
    end
  task automatic model_reset();
    left = SETS;
    exp_busy = 1'b1;
    exp_vr = 1'b0;
    exp_ta = '0;
    exp_lc = '0;
    exp_hc = '0;
  endtask
  // Effect of the coming clock edge given the inputs just driven.
  task automatic model_step(input logic [7:0] pc, input logic [7:0] opc, input logic [31:0] tgt,
                            input bit wr, input bit tk, input bit fl);
    bit busy_now = left > 0;
    bit lv = 1'b0;
    logic [31:0] lt = '0;
    int s = pc % SETS, tg = pc / SETS, hw = -1, aw = -1;
    if (!busy_now)
      for (int w = WAYS - 1; w >= 0; w--)
        if (m_v[s][w] && m_tag[s][w] == tg && m_c[s][w] >= 2) begin
          lv = 1'b1;
          lt = m_t[s][w];
        end
    if (fl) begin
      exp_lc = '0;
      exp_hc = '0;
    end else begin
      if (!busy_now) exp_lc++;
      if (exp_vr) exp_hc++;
    end
    if (busy_now) begin
      for (int w = 0; w < WAYS; w++) m_v[SETS - left][w] = 1'b0;
      m_vic[SETS - left] = 0;
    end else if (wr) begin
      s = opc % SETS;
      tg = opc / SETS;
      for (int w = WAYS - 1; w >= 0; w--) if (m_v[s][w] && m_tag[s][w] == tg) hw = w;
      if (hw >= 0) begin
        if (tk) begin
          m_t[s][hw] = tgt;
          if (m_c[s][hw] < 3) m_c[s][hw]++;
        end else if (m_c[s][hw] == 0) m_v[s][hw] = 1'b0;
        else m_c[s][hw]--;
      end else if (tk) begin
        for (int w = WAYS - 1; w >= 0; w--) if (!m_v[s][w]) aw = w;
        if (aw < 0) begin
          aw = m_vic[s];
          m_vic[s] = (m_vic[s] + 1) % WAYS;
        end
        m_v[s][aw] = 1'b1;
        m_tag[s][aw] = tg;
        m_t[s][aw] = tgt;
        m_c[s][aw] = 2;
      end
    end
    if (fl) left = SETS;
    else if (busy_now) left--;
    exp_busy = left > 0;
    exp_vr = lv && !exp_busy;
    exp_ta = exp_vr ? lt : '0;
  endtask
  task automatic tick(input logic [7:0] pc, input logic [7:0] opc, input logic [31:0] tgt,
                      input bit wr, input bit tk, input bit fl);
    bus.PC = pc;
    bus.oldPC = opc;
    bus.resolvedTarget = tgt;
    bus.writeBTB = wr;
    bus.takenBranch = tk;
    bus.flush = fl;
    if (!reset) model_step(pc, opc, tgt, wr, tk, fl);
    @(negedge clk);
    #1;
  endtask
  task automatic look(input logic [7:0] pc);
    tick(pc, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic upd(input logic [7:0] opc, input logic [31:0] tgt, input bit tk);
    tick(8'h00, opc, tgt, 1'b1, tk, 1'b0);
  endtask
  task automatic count_busy(input bit wr, output int n);
    n = 0;
    while (bus.flushBusy && n < 40) begin
      n++;
      tick(8'h25, 8'h66, 32'h3000, wr, 1'b1, 1'b0);
    end
  endtask
  function automatic logic [7:0] rpc();
    return {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
  endfunction
  initial begin
    int n;
    bus.PC = '0;
    bus.oldPC = '0;
    bus.resolvedTarget = '0;
    bus.writeBTB = 1'b0;
    bus.takenBranch = 1'b0;
    bus.flush = 1'b0;
    @(posedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    #1;
    repeat (3) look(8'h25);
    reset = 1'b0;
    model_reset();
    count_busy(1'b0, n);
    chk("reset_sweep_len", 64'(n), 64'd16);
    chk("idle_lookups_after_reset", 64'(bus.lookupCount), 64'd0);
    tick(8'h47, 8'h47, 32'h0000_0ABC, 1'b1, 1'b1, 1'b0);
    chk("same_cycle_vr", 64'(bus.validRead), 64'd0);
    look(8'h47);
    chk("after_same_cycle_vr", 64'(bus.validRead), 64'd1);
    chk("after_same_cycle_ta", 64'(bus.targetAddress), 64'h0ABC);
    upd(8'h25, 32'h0000_1000, 1'b1);
    look(8'h25);
    chk("hit_25_vr", 64'(bus.validRead), 64'd1);
    chk("hit_25_ta", 64'(bus.targetAddress), 64'h1000);
    look(8'h35);
    chk("miss_35_vr", 64'(bus.validRead), 64'd0);
    chk("miss_35_ta", 64'(bus.targetAddress), 64'd0);
    upd(8'h25, 32'h0, 1'b0);
    look(8'h25);
    chk("conf1_vr", 64'(bus.validRead), 64'd0);
    upd(8'h25, 32'h0, 1'b0);
    upd(8'h25, 32'h0, 1'b0);
    upd(8'h25, 32'h0000_2000, 1'b1);
    look(8'h25);
    chk("realloc_vr", 64'(bus.validRead), 64'd1);
    chk("realloc_ta", 64'(bus.targetAddress), 64'h2000);
    tick(8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (7) look(8'h25);
    tick(8'h25, 8'h66, 32'h3000, 1'b1, 1'b1, 1'b1);
    count_busy(1'b1, n);
    chk("restart_sweep_len", 64'(n), 64'd16);
    chk("flush_lookupCount", 64'(bus.lookupCount), 64'd0);
    chk("flush_hitCount", 64'(bus.hitCount), 64'd0);
    look(8'h66);
    chk("write_during_sweep_vr", 64'(bus.validRead), 64'd0);
    upd(8'h05, 32'h0000_0500, 1'b1);
    upd(8'h15, 32'h0000_1500, 1'b1);
    upd(8'h25, 32'h0000_2500, 1'b1);
    look(8'h15);
    chk("repl_15_ta", 64'(bus.targetAddress), 64'h1500);
    look(8'h25);
    chk("repl_25_ta", 64'(bus.targetAddress), 64'h2500);
    look(8'h05);
    chk("repl_05_vr", 64'(bus.validRead), 64'd0);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        reset = 1'b1;
        model_reset();
        tick(rpc(), rpc(), $urandom, 1'b1, 1'b1, 1'b0);
        tick(rpc(), rpc(), $urandom, 1'b1, 1'b1, 1'b0);
        reset = 1'b0;
      end
      tick(rpc(), rpc(), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised set-associative branch target buffer; successor to the 16-entry direct-mapped BTB in the fetch stage.
- Predicts the next fetch PC from the current instruction PC, using a 2-bit confidence counter per entry.
- Entries are updated from branchALU resolution, with per-set round-robin replacement.
- A sweeping flush engine clears valid bits after reset or on request, so storage can map to MLAB/RAM without power-up zeroing.

Parameters:
- WIDTH, 31: MSB index of target address (target is WIDTH+1 bits).
- B_WIDTH, 7: MSB index of instruction PC (PC is B_WIDTH+1 bits).
- SETS, 16: number of sets; power of 2; IDX = log2(SETS).
- WAYS, 2: associativity; 1..4.
- TAG_BITS, 4: tag width. Constraint: IDX + TAG_BITS <= B_WIDTH+1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- PC  in  B_WIDTH+1  current fetch PC (lookup).
- oldPC  in  B_WIDTH+1  PC of resolved branch/jump.
- resolvedTarget  in  WIDTH+1  resolved target of oldPC.
- writeBTB  in  1  resolution update strobe.
- takenBranch  in  1  resolved instruction was taken (branch or jump).
- flush  in  1  single-cycle request to invalidate all entries.
- validRead  out  1  prediction valid for the PC presented in the previous cycle.
- targetAddress  out  WIDTH+1  predicted target.
- flushBusy  out  1  flush sweep in progress.
- lookupCount  out  32  lookups performed (BTB_STATS_EN only).
- hitCount  out  32  predictions issued (BTB_STATS_EN only).

Behaviour:
- Addressing:
  - index = PC[IDX-1:0]
  - tag = PC[IDX+TAG_BITS-1:IDX]
  - oldPC is split the same way.
- Entry fields: valid, tag, target, conf[1:0]. Per-set state: victim pointer (log2 WAYS bits, 0 when WAYS=1).
- Lookup:
  - Set contents are registered on the posedge.
  - Tag compare is combinational on the registered set against the registered PC tag.
  - Latency: 1 cycle.
  - validRead = 1 iff some way is valid, tag-equal and conf >= 2, and flushBusy = 0.
  - targetAddress = target of the lowest-numbered matching way; 0 when validRead = 0.
- Update (writeBTB = 1, flushBusy = 0), set/tag from oldPC:
  - Hit, taken: target <= resolvedTarget; conf saturating increment (max 3).
  - Hit, not taken: if conf = 0, clear valid; else conf decrements.
  - Miss, taken: allocate the lowest-numbered invalid way, else the victim-pointer way. Write valid = 1, tag, target, conf = 2. Victim pointer advances (mod WAYS) only when the victim way is used.
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same set: the lookup sees pre-update contents (read-before-write).
- Flush FSM, states IDLE and SWEEP, with a counter ptr of IDX bits:
  - reset asserted (async): state = SWEEP, ptr = 0, flushBusy = 1, validRead = 0, targetAddress = 0, counters = 0.
  - SWEEP: each cycle clears valid for all ways of set ptr and resets its victim pointer; ptr increments.
  - At ptr = SETS-1, return to IDLE next cycle. The sweep takes exactly SETS cycles.
  - IDLE + flush: go to SWEEP, ptr = 0, next cycle.
  - SWEEP + flush: ptr restarts at 0.
  - writeBTB is ignored while flushBusy = 1.
  - flushBusy is registered: it is high for the SETS cycles of the sweep and low in IDLE.
- Reset asserted mid-sweep or mid-update: the sweep restarts from 0 and the pending update is dropped.

Optional Feature:
- Macro BTB_STATS_EN.
- Defined: lookupCount increments every cycle flushBusy = 0; hitCount increments every cycle validRead = 1. Both are wrap-around 32-bit counters, cleared by reset and by flush.
- Undefined: both outputs tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset, then hold 16 cycles -> flushBusy = 1 for exactly 16 cycles after deassert; validRead = 0 throughout, including any PC = 0x25 lookups.
- Update oldPC = 0x25, target 0x0000_1000, taken; next cycle PC = 0x25 -> validRead = 1 and targetAddress = 0x0000_1000 one cycle later. PC = 0x35 (same set, tag mismatch) -> validRead = 0.
- oldPC = 0x25 resolved not-taken twice (conf 2->1->0) -> validRead = 0 after the first update. A third not-taken -> entry invalid; a subsequent taken update reallocates with conf = 2.
- WAYS = 2: taken updates to 0x05, 0x15, then 0x25 (set 5) -> 0x25 replaces way 0 (victim pointer); lookups hit 0x15 and 0x25, miss 0x05.
- Update 0x25 and lookup 0x25 in the same cycle on an empty entry -> validRead = 0 that lookup; hit on the next lookup.
- Assert flush mid-sweep at ptr = 7 -> sweep restarts, flushBusy stays high 16 more cycles; a writeBTB during the sweep has no effect afterward. With BTB_STATS_EN, hitCount and lookupCount read 0 after flush.
